// File: rtl/btn_cond_pkg.sv
// Shared types and sizing helpers for the push-button conditioner.
package btn_cond_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT_P  = 2'd1,
    PRESSED = 2'd2,
    WAIT_R  = 2'd3
  } btn_state_t;

  // Bits needed to hold values 0..max_val (never less than one bit).
  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/btn_chan.sv
// One button channel: 2-FF synchroniser, strobe-sampled debounce FSM,
// hold/repeat counting and registered level/tick outputs.
//
//   state   | meaning
//   --------+--------------------------------------------------------
//   IDLE    | released and stable, level = 0
//   WAIT_P  | input high, qualifying press (scnt agreeing samples)
//   PRESSED | pressed and stable, level = 1, hcnt counting the hold
//   WAIT_R  | input low, qualifying release, hold count keeps running
module btn_chan
  import btn_cond_pkg::*;
#(
  parameter int STABLE_SAMPLES = 3,
  parameter int HOLD_SAMPLES   = 100,
  parameter int REPEAT_SAMPLES = 20
) (
  input  logic clk,
  input  logic reset,
  input  logic strobe,
  input  logic btn,
  output logic level,
  output logic press_tick,
  output logic release_tick,
  output logic long_tick,
  output logic repeat_tick
);

  localparam int SW = cnt_width(STABLE_SAMPLES);
  localparam int HW = cnt_width(HOLD_SAMPLES + REPEAT_SAMPLES);
  localparam logic [SW-1:0] STABLE_C = SW'(STABLE_SAMPLES);
  localparam logic [HW-1:0] HOLD_C   = HW'(HOLD_SAMPLES);
  localparam logic [HW-1:0] WRAP_C   = HW'(HOLD_SAMPLES + REPEAT_SAMPLES);

  logic          sync_q, s;
  btn_state_t    state, state_n;
  logic [SW-1:0] scnt, scnt_n, scnt_inc;
  logic [HW-1:0] hcnt, hcnt_n, hcnt_inc, hcnt_adv;
  logic          hold_long, hold_rep;
  logic          level_n, press_n, release_n, long_n, repeat_n;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q <= 1'b0;
      s      <= 1'b0;
    end else begin
      sync_q <= btn;
      s      <= sync_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      scnt         <= '0;
      hcnt         <= '0;
      level        <= 1'b0;
      press_tick   <= 1'b0;
      release_tick <= 1'b0;
      long_tick    <= 1'b0;
      repeat_tick  <= 1'b0;
    end else begin
      state        <= state_n;
      scnt         <= scnt_n;
      hcnt         <= hcnt_n;
      level        <= level_n;
      press_tick   <= press_n;
      release_tick <= release_n;
      long_tick    <= long_n;
      repeat_tick  <= repeat_n;
    end
  end

  assign scnt_inc  = scnt + SW'(1);
  assign hcnt_inc  = hcnt + HW'(1);
  assign hold_long = (hcnt_inc == HOLD_C);
  assign hold_rep  = (hcnt_inc == WRAP_C);
  // Reloading to HOLD after each repeat keeps hcnt bounded for any hold time.
  assign hcnt_adv  = hold_rep ? HOLD_C : hcnt_inc;

  always_comb begin
    state_n   = state;
    scnt_n    = scnt;
    hcnt_n    = hcnt;
    level_n   = level;
    press_n   = 1'b0;
    release_n = 1'b0;
    long_n    = 1'b0;
    repeat_n  = 1'b0;
    if (strobe) begin
      unique case (state)
        IDLE: begin
          if (s) begin
            if (STABLE_SAMPLES == 1) begin
              state_n = PRESSED;
              level_n = 1'b1;
              press_n = 1'b1;
              scnt_n  = '0;
              hcnt_n  = '0;
            end else begin
              state_n = WAIT_P;
              scnt_n  = SW'(1);
            end
          end
        end
        WAIT_P: begin
          if (!s) begin
            state_n = IDLE;
            scnt_n  = '0;
          end else if (scnt_inc == STABLE_C) begin
            state_n = PRESSED;
            level_n = 1'b1;
            press_n = 1'b1;
            scnt_n  = '0;
            hcnt_n  = '0;
          end else begin
            scnt_n = scnt_inc;
          end
        end
        PRESSED: begin
          if (!s) begin
            if (STABLE_SAMPLES == 1) begin
              state_n   = IDLE;
              level_n   = 1'b0;
              release_n = 1'b1;
              scnt_n    = '0;
              hcnt_n    = '0;
            end else begin
              state_n = WAIT_R;
              scnt_n  = SW'(1);
              hcnt_n  = hcnt_adv;
            end
          end else begin
            hcnt_n   = hcnt_adv;
            long_n   = hold_long;
            repeat_n = hold_rep;
          end
        end
        WAIT_R: begin
          // The hold keeps advancing while released, but ticks only fire on held samples.
          if (s) begin
            state_n  = PRESSED;
            scnt_n   = '0;
            hcnt_n   = hcnt_adv;
            long_n   = hold_long;
            repeat_n = hold_rep;
          end else if (scnt_inc == STABLE_C) begin
            state_n   = IDLE;
            level_n   = 1'b0;
            release_n = 1'b1;
            scnt_n    = '0;
            hcnt_n    = '0;
          end else begin
            scnt_n = scnt_inc;
            hcnt_n = hcnt_adv;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

endmodule

// File: rtl/btn_conditioner.sv
// Multi-channel push-button front end: shared sample-strobe divider feeding
// N independent debounce channels.
module btn_conditioner
  import btn_cond_pkg::*;
#(
  parameter int N              = 2,
  parameter int SAMPLE_DIV     = 1_000_000,
  parameter int STABLE_SAMPLES = 3,
  parameter int HOLD_SAMPLES   = 100,
  parameter int REPEAT_SAMPLES = 20
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] btn,
  output logic [N-1:0] level,
  output logic [N-1:0] press_tick,
  output logic [N-1:0] release_tick,
  output logic [N-1:0] long_tick,
  output logic [N-1:0] repeat_tick
);

  localparam int DW = cnt_width(SAMPLE_DIV - 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(SAMPLE_DIV - 1);

  logic [DW-1:0] div_cnt;
  logic          strobe;

  assign strobe = (div_cnt == DIV_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)       div_cnt <= '0;
    else if (strobe) div_cnt <= '0;
    else             div_cnt <= div_cnt + DW'(1);
  end

  for (genvar i = 0; i < N; i++) begin : g_chan
    btn_chan #(
      .STABLE_SAMPLES(STABLE_SAMPLES),
      .HOLD_SAMPLES  (HOLD_SAMPLES),
      .REPEAT_SAMPLES(REPEAT_SAMPLES)
    ) u_chan (
      .clk         (clk),
      .reset       (reset),
      .strobe      (strobe),
      .btn         (btn[i]),
      .level       (level[i]),
      .press_tick  (press_tick[i]),
      .release_tick(release_tick[i]),
      .long_tick   (long_tick[i]),
      .repeat_tick (repeat_tick[i])
    );
  end

endmodule

// File: tb/tb_btn_conditioner.sv
// Scenario bench for btn_conditioner: expected ticks are queued with their
// cycle stamps when stimulus is driven and matched as the DUT emits them.
module tb_btn_conditioner;

  localparam int N      = 2;
  localparam int SD     = 4;
  localparam int STABLE = 3;
  localparam int HOLD   = 5;
  localparam int REPEAT = 2;

  localparam int K_PRESS   = 0;
  localparam int K_RELEASE = 1;
  localparam int K_LONG    = 2;
  localparam int K_REPEAT  = 3;

  typedef struct {
    int cyc;
    int ch;
    int kind;
  } ev_t;

  logic         clk;
  logic         reset;
  logic [N-1:0] btn;
  logic [N-1:0] level, press_tick, release_tick, long_tick, repeat_tick;

  int  cyc    = 0;
  int  rel    = 0;
  int  checks = 0;
  int  errors = 0;
  ev_t exp_q[$];

  btn_conditioner #(
    .N             (N),
    .SAMPLE_DIV    (SD),
    .STABLE_SAMPLES(STABLE),
    .HOLD_SAMPLES  (HOLD),
    .REPEAT_SAMPLES(REPEAT)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .btn         (btn),
    .level       (level),
    .press_tick  (press_tick),
    .release_tick(release_tick),
    .long_tick   (long_tick),
    .repeat_tick (repeat_tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Strobe edges fall SD, 2*SD, ... edges after reset release.
  function automatic int next_strobe(input int e);
    return rel + SD * ((e - rel + SD - 1) / SD);
  endfunction

  function automatic string kind_name(input int k);
    case (k)
      K_PRESS:   return "press_tick";
      K_RELEASE: return "release_tick";
      K_LONG:    return "long_tick";
      default:   return "repeat_tick";
    endcase
  endfunction

  task automatic push_ev(input int c, input int ch, input int kind);
    ev_t e;
    e.cyc  = c;
    e.ch   = ch;
    e.kind = kind;
    exp_q.push_back(e);
  endtask

  task automatic scan_ticks();
    logic [3:0] t;
    int idx;
    for (int ch = 0; ch < N; ch++) begin
      t = {repeat_tick[ch], long_tick[ch], release_tick[ch], press_tick[ch]};
      for (int k = 0; k < 4; k++) begin
        if (t[k]) begin
          idx = -1;
          foreach (exp_q[j])
            if (idx < 0 && exp_q[j].cyc == cyc && exp_q[j].ch == ch && exp_q[j].kind == k) idx = j;
          checks++;
          if (idx < 0) begin
            errors++;
            $display("FAIL %s ch%0d cyc %0d: observed pulse, required none", kind_name(k), ch, cyc);
          end else begin
            exp_q.delete(idx);
          end
        end
      end
    end
    for (int j = exp_q.size() - 1; j >= 0; j--) begin
      if (exp_q[j].cyc < cyc) begin
        checks++;
        errors++;
        $display("FAIL %s ch%0d: no pulse observed, required at cyc %0d",
                 kind_name(exp_q[j].kind), exp_q[j].ch, exp_q[j].cyc);
        exp_q.delete(j);
      end
    end
  endtask

  task automatic step();
    @(negedge clk);
    scan_ticks();
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) step();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    btn   = '0;
    step(); step(); step();
    checks++; if (level !== 2'b00) begin errors++; $display("FAIL reset_level: observed %b required 00", level); end
    checks++; if (press_tick !== 2'b00) begin errors++; $display("FAIL reset_press: observed %b required 00", press_tick); end
    checks++; if (release_tick !== 2'b00) begin errors++; $display("FAIL reset_release: observed %b required 00", release_tick); end
    checks++; if (long_tick !== 2'b00) begin errors++; $display("FAIL reset_long: observed %b required 00", long_tick); end
    checks++; if (repeat_tick !== 2'b00) begin errors++; $display("FAIL reset_repeat: observed %b required 00", repeat_tick); end
    reset = 1'b0;
    rel   = cyc;
  endtask

  task automatic test_clean_press();
    int p, r;
    step();
    btn = 2'b01;
    p = next_strobe(cyc + 3) + (STABLE - 1) * SD;
    push_ev(p, 0, K_PRESS);
    wait_until(p - 1);
    checks++; if (level !== 2'b00) begin errors++; $display("FAIL clean_level_before: observed %b required 00", level); end
    wait_until(p);
    checks++; if (level !== 2'b01) begin errors++; $display("FAIL clean_level_after: observed %b required 01", level); end
    btn = 2'b00;
    r = next_strobe(cyc + 3) + (STABLE - 1) * SD;
    push_ev(r, 0, K_RELEASE);
    wait_until(r - 1);
    checks++; if (level !== 2'b01) begin errors++; $display("FAIL clean_level_held: observed %b required 01", level); end
    wait_until(r + 2);
    checks++; if (level !== 2'b00) begin errors++; $display("FAIL clean_level_released: observed %b required 00", level); end
  endtask

  task automatic test_bounce();
    for (int i = 0; i < 40; i++) begin
      step();
      if (i % 3 == 0) btn[0] = ~btn[0];
      if (i % 6 == 5) begin
        checks++;
        if (level !== 2'b00) begin errors++; $display("FAIL bounce_level i=%0d: observed %b required 00", i, level); end
      end
    end
    btn = 2'b00;
    wait_until(cyc + 6 * SD);
    checks++; if (level !== 2'b00) begin errors++; $display("FAIL bounce_level_end: observed %b required 00", level); end
  endtask

  task automatic test_long_press();
    int p, r;
    step();
    btn = 2'b01;
    p = next_strobe(cyc + 3) + (STABLE - 1) * SD;
    push_ev(p, 0, K_PRESS);
    push_ev(p + HOLD * SD, 0, K_LONG);
    for (int j = 1; j <= 3; j++) push_ev(p + (HOLD + REPEAT * j) * SD, 0, K_REPEAT);
    wait_until(p + (HOLD + 1) * SD);
    checks++; if (level !== 2'b01) begin errors++; $display("FAIL long_level_hold: observed %b required 01", level); end
    wait_until(p + (HOLD + 3 * REPEAT) * SD);
    btn = 2'b00;
    r = next_strobe(cyc + 3) + (STABLE - 1) * SD;
    push_ev(r, 0, K_RELEASE);
    wait_until(r - 1);
    checks++; if (level !== 2'b01) begin errors++; $display("FAIL long_level_qualify: observed %b required 01", level); end
    wait_until(r + 2);
    checks++; if (level !== 2'b00) begin errors++; $display("FAIL long_level_released: observed %b required 00", level); end
  endtask

  task automatic test_release_glitch();
    int p, g, r;
    step();
    btn = 2'b01;
    p = next_strobe(cyc + 3) + (STABLE - 1) * SD;
    g = p + 2 * SD;
    push_ev(p, 0, K_PRESS);
    push_ev(p + HOLD * SD, 0, K_LONG);
    wait_until(g - 3);
    btn = 2'b00;
    wait_until(g);
    btn = 2'b01;
    wait_until(g + 1);
    checks++; if (level !== 2'b01) begin errors++; $display("FAIL glitch_level_during: observed %b required 01", level); end
    wait_until(g + SD + 1);
    checks++; if (level !== 2'b01) begin errors++; $display("FAIL glitch_level_after: observed %b required 01", level); end
    wait_until(p + HOLD * SD);
    btn = 2'b00;
    r = next_strobe(cyc + 3) + (STABLE - 1) * SD;
    push_ev(r, 0, K_RELEASE);
    wait_until(r + 2);
    checks++; if (level !== 2'b00) begin errors++; $display("FAIL glitch_level_released: observed %b required 00", level); end
  endtask

  task automatic test_reset_mid_press();
    int p, r;
    step();
    btn = 2'b01;
    p = next_strobe(cyc + 3) + (STABLE - 1) * SD;
    push_ev(p, 0, K_PRESS);
    wait_until(p + 2);
    checks++; if (level !== 2'b01) begin errors++; $display("FAIL midrst_level_pre: observed %b required 01", level); end
    reset = 1'b1;
    #1;
    checks++;
    if ({level, press_tick, release_tick, long_tick, repeat_tick} !== '0) begin
      errors++;
      $display("FAIL midrst_outputs: observed %b required all zero",
               {level, press_tick, release_tick, long_tick, repeat_tick});
    end
    step(); step();
    reset = 1'b0;
    rel   = cyc;
    p = next_strobe(cyc + 3) + (STABLE - 1) * SD;
    push_ev(p, 0, K_PRESS);
    wait_until(p - 1);
    checks++; if (level !== 2'b00) begin errors++; $display("FAIL midrst_requalify: observed %b required 00", level); end
    wait_until(p);
    checks++; if (level !== 2'b01) begin errors++; $display("FAIL midrst_repress: observed %b required 01", level); end
    btn = 2'b00;
    r = next_strobe(cyc + 3) + (STABLE - 1) * SD;
    push_ev(r, 0, K_RELEASE);
    wait_until(r + 2);
  endtask

  task automatic test_simultaneous();
    int p, r;
    step();
    btn = 2'b11;
    p = next_strobe(cyc + 3) + (STABLE - 1) * SD;
    push_ev(p, 0, K_PRESS);
    push_ev(p, 1, K_PRESS);
    wait_until(p);
    checks++; if (press_tick !== 2'b11) begin errors++; $display("FAIL simul_press: observed %b required 11", press_tick); end
    checks++; if (level !== 2'b11) begin errors++; $display("FAIL simul_level: observed %b required 11", level); end
    btn = 2'b00;
    r = next_strobe(cyc + 3) + (STABLE - 1) * SD;
    push_ev(r, 0, K_RELEASE);
    push_ev(r, 1, K_RELEASE);
    wait_until(r);
    checks++; if (release_tick !== 2'b11) begin errors++; $display("FAIL simul_release: observed %b required 11", release_tick); end
    wait_until(r + 2);
    checks++; if (level !== 2'b00) begin errors++; $display("FAIL simul_level_end: observed %b required 00", level); end
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_bounce();
    test_long_press();
    test_release_glitch();
    test_reset_mid_press();
    test_simultaneous();
    wait_until(cyc + 4 * SD);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: observed %0d pending, required 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed no completion, required finish before timeout");
    $fatal(1);
  end

endmodule
